// File: rtl/pcie_recv_pkg.sv
// Shared definitions for the PCIE receive path: control FSM encoding and the
// word field positions also used by the transmitter's destination demuxes.
package pcie_recv_pkg;
  localparam int DEST_BIT = 4;
  localparam int VC_BIT   = 5;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  function automatic logic wrong_dest(input logic src, input logic dest);
    return src != dest;
  endfunction
endpackage

// File: rtl/pcie_recv_if.sv
// Bus bundle between pcie_recv, the transmitter's D0/D1 FIFOs and the downstream sink.
interface pcie_recv_if #(
  parameter int DATA_W = 6
);
  logic [DATA_W-1:0] data_D0;
  logic [DATA_W-1:0] data_D1;
  logic              empty_D0;
  logic              empty_D1;
  logic              pop_D0;
  logic              pop_D1;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              ready_in;

  modport slave (
    input  data_D0, data_D1, empty_D0, empty_D1, ready_in,
    output pop_D0, pop_D1, data_out, valid_out
  );

  modport master (
    output data_D0, data_D1, empty_D0, empty_D1, ready_in,
    input  pop_D0, pop_D1, data_out, valid_out
  );
endinterface

// File: rtl/pcie_recv_buf.sv
// Synchronous skid FIFO for the merged receive stream; a write into a full
// buffer is accepted when a read happens in the same cycle.
module pcie_recv_buf #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  input  logic [1:0]               umbral,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;
  logic [AW:0]       thresh;

  assign empty       = (count == '0);
  assign full        = (count == (AW+1)'(DEPTH));
  assign thresh      = (AW+1)'(DEPTH) - (AW+1)'(umbral);
  assign almost_full = (count >= thresh);
  assign rd_data     = mem[rd_ptr];
  assign do_rd       = rd_en & ~empty;
  assign do_wr       = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/pcie_recv.sv
// Receive end of the PCIE path: drains the D0/D1 FIFOs, checks each word's
// destination bit and merges both streams. Define PCIE_RECV_COUNTERS_EN to build cnt_D0/cnt_D1.
//   state  | meaning
//   RESET  | held in reset, everything cleared
//   INIT   | threshold latched every cycle, no pops
//   IDLE   | nothing to move
//   ACTIVE | draining sources / buffer
//   ERROR  | wrong-destination word seen, pops stopped until init/reset
module pcie_recv
  import pcie_recv_pkg::*;
#(
  parameter int DATA_W    = 6,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             init,
  input  logic [1:0]       umbral_out,
  pcie_recv_if.slave       bus,
  output logic             almost_full_out,
  output logic [CNT_W-1:0] cnt_D0,
  output logic [CNT_W-1:0] cnt_D1,
  output logic             active_out,
  output logic             idle_out,
  output logic             error_out
);
  localparam int AW = $clog2(BUF_DEPTH);

  state_t            state;
  state_t            state_nx;
  logic [1:0]        umbral;
  logic              in_flight;
  logic              src;
  logic              prio;
  logic              can_pop;
  logic              room;
  logic              elig0;
  logic              elig1;
  logic              pop0;
  logic              pop1;
  logic              deq;
  logic              mismatch;
  logic [DATA_W-1:0] cap_data;
  logic [AW:0]       count;
  logic              buf_empty;
  logic              buf_full;
  logic [AW+1:0]     need;
  logic [AW+1:0]     limit;

  assign deq      = bus.valid_out & bus.ready_in;
  assign can_pop  = (state == ST_IDLE) || (state == ST_ACTIVE);
  // An in-flight word already owns a slot; a same-cycle dequeue frees one.
  assign need     = (AW+2)'(count) + (AW+2)'(1);
  assign limit    = (AW+2)'(BUF_DEPTH) + (AW+2)'(deq);
  assign room     = in_flight ? (need < limit) : (~buf_full | deq);
  assign elig0    = can_pop & ~bus.empty_D0 & room;
  assign elig1    = can_pop & ~bus.empty_D1 & room;
  assign cap_data = src ? bus.data_D1 : bus.data_D0;
  assign mismatch = in_flight & wrong_dest(src, cap_data[DEST_BIT]);

  always_comb begin
    pop0 = 1'b0;
    pop1 = 1'b0;
    if (elig0 && elig1) begin
      pop1 = prio;
      pop0 = ~prio;
    end else begin
      pop0 = elig0;
      pop1 = elig1;
    end
  end

  assign bus.pop_D0 = pop0;
  assign bus.pop_D1 = pop1;

  always_comb begin
    state_nx = state;
    if (init) begin
      state_nx = ST_INIT;
    end else if (mismatch) begin
      state_nx = ST_ERROR;
    end else begin
      case (state)
        ST_RESET:  state_nx = ST_INIT;
        ST_INIT:   state_nx = ST_IDLE;
        ST_IDLE:   if (!bus.empty_D0 || !bus.empty_D1) state_nx = ST_ACTIVE;
        ST_ACTIVE: if (bus.empty_D0 && bus.empty_D1 && !in_flight && buf_empty)
                     state_nx = ST_IDLE;
        ST_ERROR:  state_nx = ST_ERROR;
        default:   state_nx = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state     <= ST_RESET;
      umbral    <= '0;
      in_flight <= 1'b0;
      src       <= 1'b0;
      prio      <= 1'b0;
    end else begin
      state     <= state_nx;
      if (state == ST_INIT) umbral <= umbral_out;
      in_flight <= pop0 | pop1;
      src       <= pop1;
      if (pop0 || pop1) prio <= pop0;
    end
  end

  pcie_recv_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .reset_L     (reset_L),
    .wr_en       (in_flight),
    .wr_data     (cap_data),
    .rd_en       (bus.ready_in),
    .rd_data     (bus.data_out),
    .umbral      (umbral),
    .count       (count),
    .empty       (buf_empty),
    .full        (buf_full),
    .almost_full (almost_full_out)
  );

  assign bus.valid_out = ~buf_empty;
  assign active_out    = (state == ST_ACTIVE);
  assign idle_out      = (state == ST_IDLE);
  assign error_out     = (state == ST_ERROR);

`ifdef PCIE_RECV_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      cnt_D0 <= '0;
      cnt_D1 <= '0;
    end else if (in_flight) begin
      if (!src && cnt_D0 != {CNT_W{1'b1}}) cnt_D0 <= cnt_D0 + 1'b1;
      if (src && cnt_D1 != {CNT_W{1'b1}})  cnt_D1 <= cnt_D1 + 1'b1;
    end
  end
`else
  assign cnt_D0 = '0;
  assign cnt_D1 = '0;
`endif
endmodule

// File: tb/tb_pcie_recv.sv
// Bench for pcie_recv: FIFO source models, per-destination scoreboard and a monitor
// that checks every word the DUT hands downstream.
module tb_pcie_recv;
  import pcie_recv_pkg::*;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       init;
  logic [1:0] umbral_out;
  logic       almost_full_out;
  logic [7:0] cnt_D0;
  logic [7:0] cnt_D1;
  logic       active_out;
  logic       idle_out;
  logic       error_out;

  pcie_recv_if #(.DATA_W(6)) ifc ();

  pcie_recv #(
    .DATA_W    (6),
    .BUF_DEPTH (4),
    .CNT_W     (8)
  ) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .init            (init),
    .umbral_out      (umbral_out),
    .bus             (ifc.slave),
    .almost_full_out (almost_full_out),
    .cnt_D0          (cnt_D0),
    .cnt_D1          (cnt_D1),
    .active_out      (active_out),
    .idle_out        (idle_out),
    .error_out       (error_out)
  );

  always #5 clk = ~clk;

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic [5:0] exp0[$];
  logic [5:0] exp1[$];
  logic [5:0] out_log[$];
  logic       pop_log[$];
  int         vectors = 0;
  int         errors  = 0;
  int         acc0    = 0;
  int         acc1    = 0;
  logic       last_p0 = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int sat(input int n);
    int cap;
`ifdef PCIE_RECV_COUNTERS_EN
    cap = 255;
`else
    cap = 0;
`endif
    return (n > cap) ? cap : n;
  endfunction

  function automatic logic [5:0] mk(input logic dest);
    logic [5:0] w;
    w = 6'($urandom);
    w[DEST_BIT] = dest;
    return w;
  endfunction

  task automatic upd_empty();
    ifc.empty_D0 = (q0.size() == 0);
    ifc.empty_D1 = (q1.size() == 0);
  endtask

  // Merging keeps order only per source, so expectations are queued by destination bit.
  task automatic src_push(input logic d, input logic [5:0] w);
    if (d) q1.push_back(w);
    else   q0.push_back(w);
    if (w[DEST_BIT]) exp1.push_back(w);
    else             exp0.push_back(w);
    upd_empty();
  endtask

  task automatic apply_reset();
    reset_L = 1'b0;
    q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
    acc0 = 0;
    acc1 = 0;
    upd_empty();
  endtask

  // One clock: sample pops mid-cycle, then play the FIFOs' registered read.
  task automatic tick();
    logic p0, p1;
    @(negedge clk);
    p0 = ifc.pop_D0;
    p1 = ifc.pop_D1;
    check("pop_both", {31'b0, p0 & p1}, 0);
    check("pop_D0_on_empty", {31'b0, p0 & (q0.size() == 0)}, 0);
    check("pop_D1_on_empty", {31'b0, p1 & (q1.size() == 0)}, 0);
    @(posedge clk);
    #1;
    last_p0 = p0;
    if (p0 && q0.size() > 0) begin
      ifc.data_D0 = q0.pop_front();
      acc0++;
      pop_log.push_back(1'b0);
    end
    if (p1 && q1.size() > 0) begin
      ifc.data_D1 = q1.pop_front();
      acc1++;
      pop_log.push_back(1'b1);
    end
    upd_empty();
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = (q0.size() == 0 && q1.size() == 0 && exp0.size() == 0 &&
              exp1.size() == 0 && idle_out === 1'b1);
    end
    check(name, {31'b0, done}, 1);
  endtask

  task automatic check_counts(input string name);
    check({name, "_cnt_D0"}, {24'b0, cnt_D0}, sat(acc0));
    check({name, "_cnt_D1"}, {24'b0, cnt_D1}, sat(acc1));
  endtask

  initial begin : monitor
    logic [5:0] w;
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (reset_L === 1'b1 && ifc.valid_out === 1'b1 && ifc.ready_in === 1'b1) begin
        w = ifc.data_out;
        out_log.push_back(w);
        if (w[DEST_BIT]) begin
          check("out_expected_dest1", {31'b0, exp1.size() != 0}, 1);
          if (exp1.size() != 0) begin
            e = exp1.pop_front();
            check("out_data_dest1", {26'b0, w}, {26'b0, e});
          end
        end else begin
          check("out_expected_dest0", {31'b0, exp0.size() != 0}, 1);
          if (exp0.size() != 0) begin
            e = exp0.pop_front();
            check("out_data_dest0", {26'b0, w}, {26'b0, e});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d miscompares so far", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [5:0] w;
    logic       found;
    reset_L      = 1'b0;
    init         = 1'b0;
    umbral_out   = 2'd2;
    ifc.ready_in = 1'b1;
    ifc.data_D0  = '0;
    ifc.data_D1  = '0;
    upd_empty();
    repeat (2) @(posedge clk);
    #1;
    repeat (2) tick();
    check("reset_status", {29'b0, active_out, idle_out, error_out}, 0);
    check("reset_valid", {31'b0, ifc.valid_out}, 0);
    check("reset_af", {31'b0, almost_full_out}, 0);
    check_counts("reset");

    reset_L = 1'b1;
    init    = 1'b1;
    repeat (2) tick();
    check("init_status", {29'b0, active_out, idle_out, error_out}, 0);
    init = 1'b0;
    repeat (2) tick();
    check("idle_status", {29'b0, active_out, idle_out, error_out}, 3'b010);

    // Two-cycle latency from pop to data_out on an empty buffer.
    w = mk(1'b0);
    src_push(1'b0, w);
    tick();
    check("lat_pop", {31'b0, last_p0}, 1);
    check("lat_valid_early", {31'b0, ifc.valid_out}, 0);
    tick();
    check("lat_valid", {31'b0, ifc.valid_out}, 1);
    check("lat_data", {26'b0, ifc.data_out}, {26'b0, w});
    wait_drain(20, "lat_drain");

    // Almost-full at threshold 4-2=2.
    ifc.ready_in = 1'b0;
    w = mk(1'b0);
    src_push(1'b0, w);
    repeat (4) tick();
    check("af_one_word", {31'b0, almost_full_out}, 0);
    src_push(1'b0, mk(1'b0));
    src_push(1'b0, mk(1'b0));
    repeat (5) tick();
    check("af_three_words", {31'b0, almost_full_out}, 1);
    check("af_head", {26'b0, ifc.data_out}, {26'b0, w});
    ifc.ready_in = 1'b1;
    wait_drain(30, "af_drain");
    check("af_cleared", {31'b0, almost_full_out}, 0);

    // Round robin with both sources loaded.
    pop_log.delete();
    out_log.delete();
    for (int i = 0; i < 4; i++) begin
      src_push(1'b0, mk(1'b0));
      src_push(1'b1, mk(1'b1));
    end
    wait_drain(60, "rr_drain");
    check("rr_pops", pop_log.size(), 8);
    check("rr_outs", out_log.size(), 8);
    for (int i = 0; i < pop_log.size(); i++)
      check("rr_alternate", {31'b0, pop_log[i]}, {31'b0, pop_log[0] ^ i[0]});
    for (int i = 0; i < out_log.size() && i < pop_log.size(); i++) begin
      w = out_log[i];
      check("rr_out_order", {31'b0, w[DEST_BIT]}, {31'b0, pop_log[i]});
    end
    check_counts("rr");

    // Backpressure: exactly a buffer's worth accepted.
    ifc.ready_in = 1'b0;
    for (int i = 0; i < 10; i++) src_push(1'b0, mk(1'b0));
    repeat (12) tick();
    check("bp_left_in_fifo", q0.size(), 6);
    check("bp_valid", {31'b0, ifc.valid_out}, 1);
    check("bp_af", {31'b0, almost_full_out}, 1);
    check("bp_active", {31'b0, active_out}, 1);
    ifc.ready_in = 1'b1;
    wait_drain(60, "bp_drain");

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) src_push(1'b0, mk(1'b0));
      if ($urandom_range(0, 2) == 0) src_push(1'b1, mk(1'b1));
      ifc.ready_in = ($urandom_range(0, 3) != 0);
      tick();
    end
    ifc.ready_in = 1'b1;
    wait_drain(1500, "rand_drain");
    check_counts("rand");

    // Wrong destination on D1.
    ifc.ready_in = 1'b0;
    src_push(1'b1, 6'b000101);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      found = ifc.valid_out;
    end
    check("mm_captured", {31'b0, found}, 1);
    check("mm_error", {31'b0, error_out}, 1);
    src_push(1'b0, mk(1'b0));
    src_push(1'b0, mk(1'b0));
    repeat (6) tick();
    check("mm_no_pops", q0.size(), 2);
    check("mm_head", {26'b0, ifc.data_out}, 32'h05);
    ifc.ready_in = 1'b1;
    repeat (3) tick();
    check("mm_drained", {31'b0, ifc.valid_out}, 0);
    check("mm_sticky", {31'b0, error_out}, 1);
    init = 1'b1;
    tick();
    init = 1'b0;
    tick();
    check("mm_recovered", {31'b0, error_out}, 0);
    wait_drain(30, "mm_drain");
    check_counts("mm");

    // Reset with a word in flight.
    for (int i = 0; i < 3; i++) src_push(1'b0, mk(1'b0));
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      tick();
      found = last_p0;
    end
    check("rst_pop_seen", {31'b0, found}, 1);
    apply_reset();
    tick();
    check("rst_valid", {31'b0, ifc.valid_out}, 0);
    check("rst_status", {29'b0, active_out, idle_out, error_out}, 0);
    check_counts("rst");
    reset_L = 1'b1;
    init    = 1'b1;
    tick();
    check("rst_init_status", {29'b0, active_out, idle_out, error_out}, 0);
    check("rst_init_valid", {31'b0, ifc.valid_out}, 0);
    init = 1'b0;
    repeat (2) tick();
    check("rst_idle", {31'b0, idle_out}, 1);

`ifdef PCIE_RECV_COUNTERS_EN
    for (int i = 0; i < 260; i++) src_push(1'b0, mk(1'b0));
    wait_drain(2000, "sat_drain");
    check("sat_cnt_D0", {24'b0, cnt_D0}, 255);
    check_counts("sat");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
